// File: rtl/vector_scale_add_pkg.sv
// Shared widths for the vector scale-and-add datapath.
// Q16.16 operands multiply straight into Q32.32, so no alignment shift is needed.
package vector_scale_add_pkg;
  localparam int IN_W      = 32;
  localparam int ACC_W     = 64;
  localparam int FRAC_BITS = 16;
endpackage

// File: rtl/vsad_lane.sv
// One lane of the scale-and-add: p = w*x + y.
// Three register stages with a shared clock enable and asynchronous clear.
module vsad_lane
  import vector_scale_add_pkg::*;
(
  input  logic             clk,
  input  logic             sclr,
  input  logic             ce,
  input  logic [IN_W-1:0]  i_w,
  input  logic [IN_W-1:0]  i_x,
  input  logic [ACC_W-1:0] i_y,
  output logic [ACC_W-1:0] o_p
);

  logic signed [IN_W-1:0]  r_w;
  logic signed [IN_W-1:0]  r_x;
  logic        [ACC_W-1:0] r_y1;
  logic signed [ACC_W-1:0] r_prod;
  logic        [ACC_W-1:0] r_y2;
  logic        [ACC_W-1:0] r_sum;

  // Both operands are signed, so they sign-extend to 64 bits and the
  // truncated product equals the exact full-precision product.
  logic signed [ACC_W-1:0] w_prod;
  assign w_prod = r_w * r_x;

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      r_w    <= '0;
      r_x    <= '0;
      r_y1   <= '0;
      r_prod <= '0;
      r_y2   <= '0;
      r_sum  <= '0;
    end else if (ce) begin
      r_w    <= i_w;
      r_x    <= i_x;
      r_y1   <= i_y;
      r_prod <= w_prod;
      r_y2   <= r_y1;
      r_sum  <= r_prod + r_y2;
    end
  end

  assign o_p = r_sum;

endmodule

// File: rtl/vector_scale_add.sv
// Element-wise P[i] = w*X[i] + Y[i] across LENGTH parallel lanes.
// Flow control: no valid/ready; ce high advances all stages one step, ce low freezes them.
module vector_scale_add
  import vector_scale_add_pkg::*;
#(
  parameter int LENGTH = 5
) (
  input  logic                    clk,
  input  logic                    sclr,
  input  logic                    ce,
  input  logic [IN_W-1:0]         w,
  input  logic [IN_W*LENGTH-1:0]  X,
  input  logic [ACC_W*LENGTH-1:0] Y,
  output logic [ACC_W*LENGTH-1:0] P
);

  genvar g;
  generate
    for (g = 0; g < LENGTH; g++) begin : g_lane
      vsad_lane u_lane (
        .clk  (clk),
        .sclr (sclr),
        .ce   (ce),
        .i_w  (w),
        .i_x  (X[g*IN_W +: IN_W]),
        .i_y  (Y[g*ACC_W +: ACC_W]),
        .o_p  (P[g*ACC_W +: ACC_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_vector_scale_add.sv
// Directed bench for vector_scale_add (LENGTH=5): expected vectors are queued at issue
// and popped by a monitor when a tracked vector reaches P.
module tb_vector_scale_add;
  localparam int L  = 5;
  localparam int PW = 64 * L;
  localparam int XW = 32 * L;

  // clock / reset
  logic          clk  = 1'b0;
  logic          sclr = 1'b0;
  logic          ce   = 1'b0;
  logic [31:0]   w    = '0;
  logic [XW-1:0] X    = '0;
  logic [PW-1:0] Y    = '0;
  logic [PW-1:0] P;

  always #5 clk = ~clk;

  vector_scale_add #(.LENGTH(L)) dut (
    .clk  (clk),
    .sclr (sclr),
    .ce   (ce),
    .w    (w),
    .X    (X),
    .Y    (Y),
    .P    (P)
  );

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] e_cur;
  int            n_cmp = 0;
  int            n_err = 0;
  logic          issue = 1'b0;
  logic [2:0]    vpipe = '0;
  logic          fresh = 1'b0;

  // Tracks which enabled edges carried a queued vector; 3 enabled edges to P.
  always @(posedge clk or posedge sclr) begin
    if (sclr) begin
      vpipe <= '0;
      fresh <= 1'b0;
    end else begin
      fresh <= ce;
      if (ce) vpipe <= {vpipe[1:0], issue};
    end
  end

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (fresh && vpipe[2]) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL monitor: output with empty expected queue, got %h", P);
      end else begin
        e_cur = exp_q.pop_front();
        check("result", P, e_cur);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] tw, input logic [XW-1:0] tx,
                      input logic [PW-1:0] ty, input logic [PW-1:0] te);
    @(negedge clk);
    w = tw; X = tx; Y = ty; ce = 1'b1; issue = 1'b1;
    exp_q.push_back(te);
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b1; issue = 1'b0;
    end
  endtask

  task automatic hold(input int n, input logic [PW-1:0] te);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b0; issue = 1'b0; X = ~X; w = ~w;
      #1 check("stall_hold", P, te);
    end
  endtask

  // directed vectors
  localparam logic [31:0]   W1 = 32'h0000_8000;
  localparam logic [XW-1:0] X1 = {32'hffff_8000, 32'h0000_0000, 32'h0019_c000, 32'h0001_0000, 32'h0004_8000};
  localparam logic [PW-1:0] Y1 = {64'h0, 64'h00000064_80000000, 64'h0, 64'h0, 64'h0};
  localparam logic [PW-1:0] E1 = {64'hFFFFFFFF_C0000000, 64'h00000064_80000000, 64'h0000000C_E0000000,
                                  64'h00000000_80000000, 64'h00000002_40000000};

  localparam logic [31:0]   W2 = 32'h0000_4000;
  localparam logic [XW-1:0] X2 = {32'h0, 32'h0, 32'h0, 32'h0000_0000, 32'hfff1_8000};
  localparam logic [PW-1:0] Y2 = {64'h0, 64'h0, 64'h0, 64'h00000004_00000000, 64'h0};
  localparam logic [PW-1:0] E2 = {64'h0, 64'h0, 64'h0, 64'h00000004_00000000, 64'hFFFFFFFC_60000000};

  localparam logic [31:0]   W3 = 32'h8000_0000;
  localparam logic [XW-1:0] X3 = {5{32'h8000_0000}};
  localparam logic [PW-1:0] Y3 = {64'h0, 64'h0, 64'hC0000000_00000000, 64'h0, 64'h40000000_00000000};
  localparam logic [PW-1:0] E3 = {64'h40000000_00000000, 64'h40000000_00000000, 64'h0,
                                  64'h40000000_00000000, 64'h80000000_00000000};

  localparam logic [31:0]   W4 = 32'h0000_0000;
  localparam logic [XW-1:0] X4 = {32'h1234_5678, 32'hffff_ffff, 32'h8000_0000, 32'h7fff_ffff, 32'h0001_0000};
  localparam logic [PW-1:0] Y4 = {64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210, 64'h80000000_00000001,
                                  64'h7FFFFFFF_FFFFFFFF, 64'hDEADBEEF_CAFEF00D};

  localparam logic [31:0]   W5 = 32'hFFFF_0000;
  localparam logic [XW-1:0] X5 = {32'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_0000, 32'h0002_0000};
  localparam logic [PW-1:0] Y5 = {64'h5, 64'h0, 64'h0, 64'h0, 64'h0};
  localparam logic [PW-1:0] E5 = {64'h00000000_00000005, 64'hFFFF8000_00010000, 64'hFFFFFFFF_FFFF0000,
                                  64'h00000001_00000000, 64'hFFFFFFFE_00000000};

  initial begin
    int budget;
    // reset state
    #1 sclr = 1'b1;
    #1 check("reset_state", P, '0);
    repeat (2) @(negedge clk);
    sclr = 1'b0;

    // back-to-back distinct vectors, in order
    send(W1, X1, Y1, E1);
    send(W2, X2, Y2, E2);
    send(W3, X3, Y3, E3);
    send(W4, X4, Y4, Y4);
    send(W5, X5, Y5, E5);
    bubble(4);

    // stall: B sampled on its 1st enabled edge, then 4 cycles with ce low
    send(W1, X1, Y1, E1);
    bubble(2);
    send(W5, X5, Y5, E5);
    hold(4, E1);
    bubble(4);

    // asynchronous reset with pipeline full
    send(W2, X2, Y2, E2);
    send(W4, X4, Y4, Y4);
    send(W5, X5, Y5, E5);
    @(posedge clk);
    #1 check("pre_reset", P, E2);
    #1 sclr = 1'b1;
    #1 check("async_clear", P, '0);
    @(negedge clk);
    exp_q.delete();
    ce = 1'b0; issue = 1'b0;
    #1 check("reset_hold", P, '0);
    sclr = 1'b0;
    send(W3, X3, Y3, E3);
    @(negedge clk);
    ce = 1'b1; issue = 1'b0;
    #1 check("post_reset_edge1", P, '0);
    @(negedge clk);
    #1 check("post_reset_edge2", P, '0);

    // drain with bounded wait
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      ce = 1'b1; issue = 1'b0;
      budget++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors never emerged, want 0", exp_q.size());
    end
    bubble(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
